// File: rtl/sop_acc_pkg.sv
// sop_acc_pkg: shared defaults and the saturating accumulate helper for the SOP lane accumulator.
package sop_acc_pkg;
  localparam int LANES_DEF = 8;
  localparam int IN_W_DEF = 37;
  localparam int ACC_W_DEF = 48;
  localparam int SAT_W = 64;
  typedef struct packed {
    logic ovf;
    logic signed [SAT_W-1:0] sum;
  } sat_t;
  // Operands arrive sign-extended to SAT_W; acc_w (< SAT_W) sets the clamp range.
  function automatic sat_t sat_add(input logic signed [SAT_W-1:0] acc, input logic signed [SAT_W-1:0] in, input int acc_w);
    logic signed [SAT_W-1:0] hi, lo, s;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = ~hi;
    s = acc + in;
    return '{ovf: (s > hi) || (s < lo), sum: (s > hi) ? hi : (s < lo) ? lo : s};
  endfunction
endpackage

// File: rtl/sop_lane_acc.sv
// sop_lane_acc: one lane's saturating frame accumulator; nxt/nxt_sat expose the post-beat value.
module sop_lane_acc
  import sop_acc_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    first,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  in,
  output logic signed [ACC_W-1:0] nxt,
  output logic                    nxt_sat
);
  logic signed [ACC_W-1:0] acc;
  logic sat;
  sat_t r;
  always_comb begin
    r = sat_add(SAT_W'(acc), SAT_W'(in), ACC_W);
    nxt = first ? ACC_W'(in) : ACC_W'(r.sum);
    nxt_sat = !first && (sat || r.ovf);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= nxt;
      sat <= nxt_sat;
    end
  end
endmodule

// File: rtl/sop_lane_accumulator_8.sv
// sop_lane_accumulator_8: per-lane saturating frame sums of the SOP bank output, held in a
// valid/ready output buffer; only the frame-closing beat stalls on a full buffer.
module sop_lane_accumulator_8
  import sop_acc_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);
  localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic [CW-1:0] cnt;
  logic [LANES*ACC_W-1:0] nxt;
  logic [LANES-1:0] nxt_sat;
  logic last, fire;
  always_comb begin
    last = cnt == CW'(FRAME_LEN - 1);
    in_ready = !out_valid || out_ready || !last;
    fire = in_valid && in_ready;
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sop_lane_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .reset(reset),
      .first(cnt == '0),
      .en(fire),
      .in(in_data[k*IN_W +: IN_W]),
      .nxt(nxt[k*ACC_W +: ACC_W]),
      .nxt_sat(nxt_sat[k])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= '0;
    end else begin
      if (fire) cnt <= last ? '0 : cnt + CW'(1);
      if (fire && last) begin
        out_valid <= 1'b1;
        out_data <= nxt;
        out_sat <= nxt_sat;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sop_lane_accumulator_8.sv
// tb_sop_lane_accumulator_8: scoreboard bench over three configurations (FRAME_LEN 4, ACC_W 40/FRAME_LEN 16, FRAME_LEN 1).
module tb_sop_lane_accumulator_8;
  typedef struct {
    logic [383:0] d;
    logic [7:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic vld[3], ordy[3], rdy[3], ov[3];
  logic [295:0] din[3];
  logic [383:0] od4, od1;
  logic [319:0] ods;
  logic [7:0] os[3];
  exp_t q0[$], qs[$], q1[$];
  int tests = 0, fails = 0, cyc = 0;
  longint a[8], e[8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sop_lane_accumulator_8 #(.FRAME_LEN(4)) d4 (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od4), .out_sat(os[0]));
  sop_lane_accumulator_8 #(.ACC_W(40), .FRAME_LEN(16)) ds (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(ods), .out_sat(os[1]));
  sop_lane_accumulator_8 #(.FRAME_LEN(1)) d1 (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od1), .out_sat(os[2]));

  task automatic chk(input string nm, input logic [383:0] got, input logic [383:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  function automatic logic [295:0] pk_in(input longint v[8]);
    logic [295:0] r = '0;
    for (int k = 0; k < 8; k++) r[k*37 +: 37] = v[k][36:0];
    return r;
  endfunction

  function automatic logic [383:0] pk_out(input longint v[8], input int w);
    logic [383:0] r = '0;
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < w; b++) r[k*w + b] = v[k][b];
    return r;
  endfunction

  task automatic push(input int sel, input longint v[8], input int w, input logic [7:0] s);
    exp_t x;
    x.d = pk_out(v, w);
    x.s = s;
    if (sel == 0) q0.push_back(x);
    else if (sel == 1) qs.push_back(x);
    else q1.push_back(x);
  endtask

  // Call at posedge+1; returns at posedge+1 after the beat is taken, with the stall count.
  task automatic send(input int sel, input logic [295:0] d, output int st);
    st = 0;
    vld[sel] = 1'b1;
    din[sel] = d;
    @(negedge clk);
    while (!rdy[sel] && st < 50) begin
      st++;
      @(negedge clk);
    end
    if (st == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout[%0d]: in_ready stayed 0, required 1", sel);
    end
    @(posedge clk);
    #1 vld[sel] = 1'b0;
  endtask

  task automatic mon(input int sel, input logic [383:0] d, input logic [7:0] s);
    exp_t x;
    int n;
    n = sel == 0 ? q0.size() : sel == 1 ? qs.size() : q1.size();
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL spurious_out[%0d]: got result %h, required none", sel, d);
      return;
    end
    if (sel == 0) x = q0.pop_front();
    else if (sel == 1) x = qs.pop_front();
    else x = q1.pop_front();
    chk($sformatf("out_data[%0d]", sel), d, x.d);
    chk($sformatf("out_sat[%0d]", sel), 384'(s), 384'(x.s));
  endtask

  always @(negedge clk) if (!reset && ov[0] && ordy[0]) mon(0, od4, os[0]);
  always @(negedge clk) if (!reset && ov[1] && ordy[1]) mon(1, 384'(ods), os[1]);
  always @(negedge clk) if (!reset && ov[2] && ordy[2]) mon(2, od1, os[2]);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, c0;
    exp_t ea;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      ordy[i] = 1'b1;
      din[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), 384'(ov[i]), '0);
      chk($sformatf("rst_ready%0d", i), 384'(rdy[i]), 384'(1));
      chk($sformatf("rst_sat%0d", i), 384'(os[i]), '0);
    end
    chk("rst_data0", od4, '0);
    chk("rst_data1", 384'(ods), '0);
    chk("rst_data2", od1, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    // constant input of 1 over a 4-beat frame
    for (int k = 0; k < 8; k++) begin a[k] = 1; e[k] = 4; end
    push(0, e, 48, 8'h00);
    repeat (4) send(0, pk_in(a), st);
    @(negedge clk);
    chk("t1_latency_valid", 384'(ov[0]), 384'(1));
    @(negedge clk);
    chk("t1_single_pulse", 384'(ov[0]), '0);
    @(posedge clk);
    #1;
    // lane k fed -(k+1)
    for (int k = 0; k < 8; k++) begin a[k] = -(k + 1); e[k] = -4 * (k + 1); end
    push(0, e, 48, 8'h00);
    repeat (4) send(0, pk_in(a), st);
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    // backpressure: frame A = 8 held, frame B = 12 closes only when out_ready rises
    for (int k = 0; k < 8; k++) begin a[k] = 2; e[k] = 8; end
    push(0, e, 48, 8'h00);
    ea.d = pk_out(e, 48);
    repeat (4) send(0, pk_in(a), st);
    for (int k = 0; k < 8; k++) begin a[k] = 3; e[k] = 12; end
    push(0, e, 48, 8'h00);
    for (int b = 0; b < 3; b++) begin
      send(0, pk_in(a), st);
      chk($sformatf("t4_beat%0d_stalls", b), 384'(st), '0);
    end
    vld[0] = 1'b1;
    din[0] = pk_in(a);
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready_low", 384'(rdy[0]), '0);
      chk("t4_held_valid", 384'(ov[0]), 384'(1));
      chk("t4_held_data", od4, ea.d);
    end
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_comb", 384'(rdy[0]), 384'(1));
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk("t4_frame2_valid", 384'(ov[0]), 384'(1));
    @(posedge clk);
    #1;
    // reset mid-frame: the two beats of 9 must vanish
    for (int k = 0; k < 8; k++) begin a[k] = 9; e[k] = 20; end
    repeat (2) send(0, pk_in(a), st);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_in_reset", 384'(rdy[0]), 384'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    push(0, e, 48, 8'h00);
    for (int k = 0; k < 8; k++) a[k] = 5;
    repeat (4) send(0, pk_in(a), st);
    @(posedge clk);
    #1;
    // saturation with ACC_W=40: lane 0 clamps high, lane 1 clamps low
    a[0] = 64'h0000_000F_FFFF_FFFF;
    a[1] = -64'h0000_0010_0000_0000;
    e[0] = 64'h0000_007F_FFFF_FFFF;
    e[1] = -64'h0000_0080_0000_0000;
    for (int k = 2; k < 8; k++) begin a[k] = k; e[k] = 16 * k; end
    push(1, e, 40, 8'h03);
    repeat (16) send(1, pk_in(a), st);
    a[0] = 1; a[1] = -1; e[0] = 16; e[1] = -16;
    push(1, e, 40, 8'h00);
    repeat (16) send(1, pk_in(a), st);
    @(posedge clk);
    #1;
    // pass-through with FRAME_LEN=1, one result per cycle
    for (int k = 0; k < 8; k++) begin a[k] = -1; e[k] = -1; end
    c0 = cyc;
    repeat (3) begin
      push(2, e, 48, 8'h00);
      send(2, pk_in(a), st);
    end
    for (int k = 0; k < 8; k++) begin a[k] = k - 3; e[k] = k - 3; end
    push(2, e, 48, 8'h00);
    send(2, pk_in(a), st);
    chk("t6_throughput_cycles", 384'(cyc - c0), 384'(4));
    repeat (4) @(posedge clk);
    #1;
    chk("end_q0_empty", 384'(q0.size()), '0);
    chk("end_qs_empty", 384'(qs.size()), '0);
    chk("end_q1_empty", 384'(q1.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sop_lane_accumulator_8.md
# sop_lane_accumulator_8

Accumulates the 8-lane, 37-bit-per-lane sum-of-products word from the 8-way `dsp_chain_2_int_sop_2_module` bank. Each lane is summed over a fixed frame of `FRAME_LEN` accepted beats, with signed saturation. The frame result is held in an output buffer under a valid/ready handshake. The block sits directly downstream of the SOP bank. Its `in_valid` is driven by the external valid delay line that matches the SOP pipeline latency.

## Interface
- `LANES`, default 8: number of lanes.
- `IN_W`, default 37: signed width of each input lane.
- `ACC_W`, default 48: signed accumulator and output width per lane; must satisfy `ACC_W >= IN_W`.
- `FRAME_LEN`, default 16: beats per frame; must be `>= 1`.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `in_data` holds a beat.
- `in_ready`  out  1: the block can accept a beat.
- `in_data`  in  `LANES*IN_W`: lane k is `in_data[k*IN_W +: IN_W]`, two's complement.
- `out_valid`  out  1: the output buffer holds a frame result.
- `out_ready`  in  1: the consumer takes the result.
- `out_data`  out  `LANES*ACC_W`: lane k is `out_data[k*ACC_W +: ACC_W]`.
- `out_sat`  out  `LANES`: per-lane flag, set when that lane saturated during the frame.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- The beat counter `cnt` runs 0..`FRAME_LEN-1` and advances only on an accepted beat. It wraps to 0 after the last beat.
- Per lane, on an accepted beat:
  - Sign-extend the input to `ACC_W`.
  - If `cnt==0`: `acc = sext(in)`, and clear the lane's saturation flag.
  - Otherwise: form `acc + sext(in)` in `ACC_W+1` bits.
    - On overflow above `2^(ACC_W-1)-1`, clamp to that value.
    - On overflow below `-2^(ACC_W-1)`, clamp to that value.
    - On either overflow, set the lane's saturation flag. The flag is sticky for the rest of the frame.
- Last beat (`cnt==FRAME_LEN-1`) accepted:
  - The final values, including this beat, load into `out_data`.
  - The saturation flags, including this beat, load into `out_sat`.
  - `out_valid` sets.
- `in_ready = !out_valid || out_ready || (cnt != FRAME_LEN-1)`. This is combinational:
  - Beats 0..`FRAME_LEN-2` of the next frame are always accepted while a result is held.
  - Only the closing beat stalls.
- Output handshake:
  - `out_valid` clears when `out_valid && out_ready`, unless a new last beat is accepted in the same cycle. In that case the buffer reloads and `out_valid` stays 1.
  - `out_data` and `out_sat` are stable while `out_valid && !out_ready`.
- `FRAME_LEN==1`: every beat is a frame, so `out = sext(in)` and `out_sat = 0`.
- Reset (asserted at any time, including mid-frame):
  - `cnt` = 0 and all accumulators = 0.
  - `out_valid` = 0, `out_data` = 0, `out_sat` = 0.
  - Any partial frame is discarded; the first beat accepted after reset is beat 0.
  - `in_ready` = 1 during and after reset.

## Timing
- Latency: the last beat is accepted in cycle t, and `out_valid`=1 with the result in cycle t+1.
- Throughput: one beat per cycle sustained while `out_ready` is held high.
- Combinational path: `out_ready` -> `in_ready`. There are no other combinational paths from inputs to outputs.
- All outputs other than `in_ready` are registered.

## Structure
- Package `sop_acc_pkg` contains:
  - default constants `LANES_DEF=8`, `IN_W_DEF=37`, `ACC_W_DEF=48`;
  - function `sat_add(acc, in)`, which returns the clamped sum and the overflow flag.
- Sub-module `sop_lane_acc`: one lane's accumulator and saturation flag. It takes `first`, `en` and `in`, and is instantiated `LANES` times via generate.
- The top level holds the beat counter, the output buffer and the handshake logic.

## Test plan
1. **Constant input.** `FRAME_LEN=4`, `out_ready=1`, every lane 1 for 4 beats -> `out_valid` pulses once, one cycle after beat 4; all lanes = 4; `out_sat=0`.
2. **Signed sums.** `FRAME_LEN=4`, lane k fed `-(k+1)` on every beat -> lane k = `-4(k+1)`, sign-extended to 48 bits; lane 7 = -32.
3. **Saturation.** `ACC_W=40`, `FRAME_LEN=16`, lane 0 fed `2^36-1` on every beat -> lane 0 = `2^39-1`, `out_sat[0]=1`, other lanes unaffected. The next frame starts with the flag cleared.
4. **Backpressure.** `FRAME_LEN=4`, `out_ready=0` after the first result:
   - Beats 0..2 of frame 2 are accepted; `in_ready` drops at beat 3.
   - The first result stays stable.
   - Raising `out_ready` accepts beat 3 in the same cycle; the next cycle shows the frame 2 result with `out_valid=1`.
5. **Reset mid-frame.** `FRAME_LEN=4`: two beats of 9, then a one-cycle `reset`, then four beats of 5 -> single result of 20 per lane; nothing emitted for the aborted frame.
6. **Pass-through.** `FRAME_LEN=1`, lane input `37'h1F_FFFF_FFFF` (-1) on every beat -> `out_data` lane = `48'hFFFF_FFFF_FFFF`, one result per cycle, `out_sat=0`.
